fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; asserting it clears all state immediately.
REQ-004 stall  input  1  holds the whole fetch pipeline for the current cycle.
REQ-005 rom_addr  output  8  address presented to the synchronous program ROM.
REQ-006 rom_en  output  1  ROM read enable; the ROM updates rom_q only on a clock edge where rom_en=1.
REQ-007 rom_q  input  24  ROM data for the address accepted at the previous enabled edge.
REQ-008 jump_enable  input  1  redirect request from the decoder.
REQ-009 jump_addr  input  8  redirect target from the decoder.
REQ-010 instr_data  output  24  instruction word to the decoder: [23:16] opcode, [15:8] arg_a, [7:0] arg_b.
REQ-011 instr_pc  output  8  address of instr_data, used by the decoder as rom_pc.
REQ-012 instr_valid  output  1  instr_data/instr_pc hold a real instruction.

Function
REQ-013 The block SHALL hold these registers:
- pc_q: next address to issue.
- f1_valid, f1_pc: address in flight in the ROM.
- instr_data, instr_pc, instr_valid: the decode-stage register.
REQ-014 Outputs SHALL be driven as follows:
- rom_addr = pc_q, combinationally.
- rom_en = !stall && !redirect.
REQ-015 advance SHALL equal !stall, and redirect SHALL equal jump_enable && instr_valid && !stall.
REQ-016 On an advance edge without redirect, the block SHALL update in one edge:
- instr_data <= rom_q, instr_pc <= f1_pc, instr_valid <= f1_valid.
- f1_pc <= pc_q, f1_valid <= 1.
- pc_q <= pc_q + 1.
REQ-017 On a redirect edge, the block SHALL load pc_q <= jump_addr and clear f1_valid and instr_valid, discarding both in-flight words.
REQ-018 jump_enable SHALL be ignored whenever instr_valid=0 or stall=1.
REQ-019 On a stall edge, every register SHALL hold its value, and rom_en=0 so that rom_q also holds.
REQ-020 While instr_valid=0, instr_data SHALL read 24'h000000, the NOP encoding, and instr_pc SHALL read 8'h00.
REQ-021 pc_q increment SHALL be modulo 256: 8'hFF + 1 = 8'h00, and the wrap SHALL produce no bubble.
REQ-022 Fetch latency SHALL be 2 advance cycles from an address issue to instr_valid=1 for that address.
REQ-023 A taken redirect SHALL produce exactly 2 bubble cycles (instr_valid=0) before the target instruction appears, when there is no stall.
REQ-024 The pipeline state SHALL be derived from {f1_valid, instr_valid}: EMPTY=00, FILL=10, RUN=11.
REQ-025 Pipeline state transitions SHALL be:
- EMPTY->FILL->RUN on successive advances.
- RUN->RUN on advance.
- Any state->EMPTY on redirect.
- No change on stall.
REQ-026 When stall and jump_enable are asserted in the same cycle, stall SHALL take precedence: no redirect; the jump is taken on the first non-stalled cycle if still requested.
REQ-027 A redirect to the address currently in pc_q SHALL still flush and incur the 2 bubbles.
REQ-028 The block SHALL be self-contained: it reads no register-file, flag or stack state and does not interpret opcodes.

Reset
REQ-029 While rst_n=0, the block SHALL hold:
- pc_q=8'h00, f1_valid=0, f1_pc=8'h00.
- instr_valid=0, instr_data=24'h000000, instr_pc=8'h00.
REQ-030 Assertion of rst_n mid-operation, including mid-redirect or mid-stall, SHALL clear all state asynchronously without waiting for clk.
REQ-031 On the first edge after rst_n rises with stall=0, the block SHALL issue address 8'h00, and instr_valid SHALL rise on the 2nd edge with instr_pc=8'h00.

Verification
REQ-032 Boot: release reset, stall=0, ROM[n]={n,n,n} -> instr_valid=0 for 1 edge; from the 2nd edge, instr_pc=00,01,02... with instr_data=ROM[instr_pc] each cycle.
REQ-033 Jump: at instr_pc=8'h05, pulse jump_enable with jump_addr=8'h40 -> 2 bubble cycles (instr_data=0), then instr_pc=8'h40, 8'h41.
REQ-034 Stall: assert stall for 3 cycles while instr_pc=8'h10 -> instr_pc, instr_data and rom_addr held for 3 cycles, rom_en=0; release -> 8'h11 follows with no lost or duplicated word.
REQ-035 Stall+jump: stall=1 and jump_enable=1 (jump_addr=8'h80) together for 2 cycles, then stall=0 -> no redirect during the stall; the redirect occurs on the release cycle; 8'h80 appears 2 cycles later.
REQ-036 Wrap: run from 8'hFE -> instr_pc sequence FE, FF, 00, 01 with instr_valid=1 throughout.
REQ-037 Async reset: assert rst_n=0 between edges while in RUN -> all outputs at reset values before the next edge; on release, the REQ-032 boot sequence repeats.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: two-stage instruction fetch (ROM address stage + decode register)
// with stall hold and decoder-driven redirect that flushes both in-flight words.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [23:0] rom_q,
  input  logic        jump_enable,
  input  logic [7:0]  jump_addr,
  output logic [23:0] instr_data,
  output logic [7:0]  instr_pc,
  output logic        instr_valid
);
  logic [7:0]  r_pc;
  logic [7:0]  r_f1_pc;
  logic        r_f1_valid;
  logic [23:0] r_instr_data;
  logic [7:0]  r_instr_pc;
  logic        r_instr_valid;
  logic        w_advance;
  logic        w_redirect;
  assign w_advance   = !stall;
  assign w_redirect  = jump_enable && r_instr_valid && w_advance;
  assign rom_addr    = r_pc;
  assign rom_en      = w_advance && !w_redirect;
  assign instr_data  = r_instr_data;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  // Bubbles load zeros so the decoder sees a NOP at pc 0 whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_f1_pc       <= '0;
      r_f1_valid    <= 1'b0;
      r_instr_data  <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc          <= jump_addr;
      r_f1_valid    <= 1'b0;
      r_instr_data  <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_advance) begin
      r_instr_data  <= r_f1_valid ? rom_q : '0;
      r_instr_pc    <= r_f1_valid ? r_f1_pc : '0;
      r_instr_valid <= r_f1_valid;
      r_f1_pc       <= r_pc;
      r_f1_valid    <= 1'b1;
      r_pc          <= r_pc + 8'd1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus pushes expected decode-stage words into a
// scoreboard queue; a monitor pops one entry per non-stalled edge and compares.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [23:0] rom_q = '0;
  logic        jump_enable = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [23:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic        edge_adv = 1'b0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_q(rom_q),
    .jump_enable(jump_enable), .jump_addr(jump_addr),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: ROM[n] = {n,n,n}
  always_ff @(posedge clk) if (rom_en) rom_q <= {3{rom_addr}};

  always @(posedge clk) edge_adv <= rst_n && !stall;

  always @(negedge clk) begin
    if (edge_adv) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got v=%0b pc=%02h data=%06h with no expected entry", instr_valid, instr_pc, instr_data);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({instr_valid, instr_pc, instr_data} !== e) begin
          errors++;
          $display("FAIL decode_word: got v=%0b pc=%02h data=%06h expected v=%0b pc=%02h data=%06h",
                   instr_valid, instr_pc, instr_data, e[32], e[31:24], e[23:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; pushes the word expected after the coming edge.
  task automatic step(input logic j, input logic [7:0] a, input logic v, input logic [7:0] pc, input int en_exp = -1);
    stall = 1'b0;
    jump_enable = j;
    jump_addr = a;
    #1;
    if (en_exp >= 0) chk("rom_en", {31'b0, rom_en}, en_exp);
    sb.push_back({v, v ? pc : 8'h00, v ? {3{pc}} : 24'h0});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stall_step(input logic j, input logic [7:0] a, input logic [7:0] ipc, input logic [7:0] addr);
    stall = 1'b1;
    jump_enable = j;
    jump_addr = a;
    #1;
    chk("stall_rom_en", {31'b0, rom_en}, 0);
    chk("stall_rom_addr", {24'b0, rom_addr}, {24'b0, addr});
    chk("stall_instr_pc", {24'b0, instr_pc}, {24'b0, ipc});
    chk("stall_instr_data", {8'b0, instr_data}, {8'b0, {3{ipc}}});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 0);
    chk({tag, "_pc"}, {24'b0, instr_pc}, 0);
    chk({tag, "_data"}, {8'b0, instr_data}, 0);
    chk({tag, "_rom_addr"}, {24'b0, rom_addr}, 0);
  endtask

  task automatic boot();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(i));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_chk("reset");
    boot();
    step(1, 8'h40, 0, 0, 0);
    step(1, 8'h33, 0, 0, 1);
    step(0, 0, 1, 8'h40);
    step(0, 0, 1, 8'h41);
    step(1, 8'h0E, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 8'h0E);
    step(0, 0, 1, 8'h0F);
    step(0, 0, 1, 8'h10);
    repeat (3) stall_step(0, 0, 8'h10, 8'h12);
    step(0, 0, 1, 8'h11);
    step(0, 0, 1, 8'h12);
    repeat (2) stall_step(1, 8'h80, 8'h12, 8'h14);
    step(1, 8'h80, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 8'h80);
    step(0, 0, 1, 8'h81);
    step(1, 8'h83, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 8'h83);
    step(0, 0, 1, 8'h84);
    step(1, 8'hFE, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 8'hFE);
    step(0, 0, 1, 8'hFF);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h01);
    #2 rst_n = 1'b0;
    #1 reset_chk("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    boot();
    #1 chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
